// File: rtl/control_sequencer_if.sv
// Strobe, decode and status signals between the control sequencer and the Datapath.
interface control_sequencer_if #(
  parameter int NREGS = 16,
  parameter int CNT_W = 16
);
  logic             Run;
  logic [31:0]      IR;
  logic             PCout, Zlowout, Zhighout, MDRout;
  logic             MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin;
  logic             IncPC, Read;
  logic [NREGS-1:0] GPRin, GPRout;
  logic [4:0]       ALU_op;
  logic             Done, Illegal;
  logic [CNT_W-1:0] Instr_count;

  modport master (
    input  Run, IR,
    output PCout, Zlowout, Zhighout, MDRout,
    output MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin,
    output IncPC, Read, GPRin, GPRout, ALU_op, Done, Illegal, Instr_count
  );

  modport slave (
    output Run, IR,
    input  PCout, Zlowout, Zhighout, MDRout,
    input  MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin,
    input  IncPC, Read, GPRin, GPRout, ALU_op, Done, Illegal, Instr_count
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch in T0-T2, register-register ALU execute in T3-T6.
module control_sequencer #(
  parameter int NREGS = 16,
  parameter int CNT_W = 16
) (
  input  logic               Clock,
  input  logic               Resetn,
  control_sequencer_if.master bus
);
  typedef enum logic [2:0] {S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done;

  logic [4:0]       op;
  logic [3:0]       ra, rb, rc;
  logic [NREGS-1:0] oh_ra, oh_rb, oh_rc;
  logic             is_bin, is_md, is_un;
  state_t           exit_st;
  logic             unused_ir;

  assign op = bus.IR[31:27];
  assign ra = bus.IR[26:23];
  assign rb = bus.IR[22:19];
  assign rc = bus.IR[18:15];
  assign unused_ir = ^bus.IR[14:0];

  assign oh_ra = NREGS'(1) << ra;
  assign oh_rb = NREGS'(1) << rb;
  assign oh_rc = NREGS'(1) << rc;

  assign is_bin = (op >= 5'd3) && (op <= 5'd10);
  assign is_md  = (op == 5'd14) || (op == 5'd15);
  assign is_un  = (op == 5'd16) || (op == 5'd17);

  // Run is only looked at here and in IDLE, so a dropped Run lets the current instruction finish.
  assign exit_st = bus.Run ? S_T0 : S_IDLE;

  always_comb begin
    state_d      = state_q;
    done         = 1'b0;
    bus.PCout    = 1'b0;
    bus.Zlowout  = 1'b0;
    bus.Zhighout = 1'b0;
    bus.MDRout   = 1'b0;
    bus.MARin    = 1'b0;
    bus.Zin      = 1'b0;
    bus.PCin     = 1'b0;
    bus.MDRin    = 1'b0;
    bus.IRin     = 1'b0;
    bus.Yin      = 1'b0;
    bus.LOin     = 1'b0;
    bus.HIin     = 1'b0;
    bus.IncPC    = 1'b0;
    bus.Read     = 1'b0;
    bus.Illegal  = 1'b0;
    bus.GPRin    = '0;
    bus.GPRout   = '0;
    bus.ALU_op   = '0;
    case (state_q)
      S_IDLE: if (bus.Run) state_d = S_T0;
      S_T0: begin
        bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1;
        state_d = S_T2;
      end
      S_T2: begin
        bus.MDRout = 1'b1; bus.IRin = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        bus.ALU_op = op;
        if (is_bin || is_md) begin
          bus.GPRout = oh_rb; bus.Yin = 1'b1; state_d = S_T4;
        end else if (is_un) begin
          bus.GPRout = oh_rb; bus.Zin = 1'b1; state_d = S_T4;
        end else begin
          bus.Illegal = 1'b1; state_d = exit_st;
        end
      end
      S_T4: begin
        bus.ALU_op = op;
        if (is_un) begin
          bus.Zlowout = 1'b1; bus.GPRin = oh_ra; done = 1'b1; state_d = exit_st;
        end else begin
          bus.GPRout = oh_rc; bus.Zin = 1'b1; state_d = S_T5;
        end
      end
      S_T5: begin
        bus.ALU_op = op;
        bus.Zlowout = 1'b1;
        if (is_md) begin
          bus.LOin = 1'b1; state_d = S_T6;
        end else begin
          bus.GPRin = oh_ra; done = 1'b1; state_d = exit_st;
        end
      end
      S_T6: begin
        bus.ALU_op = op;
        bus.Zhighout = 1'b1; bus.HIin = 1'b1; done = 1'b1; state_d = exit_st;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q + CNT_W'(done);
  end

  assign bus.Done        = done;
  assign bus.Instr_count = cnt_q;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: per-cycle expected strobe snapshots are queued per instruction and compared at negedge.
module tb_control_sequencer;
  typedef struct packed {
    logic [15:0] stb;
    logic [15:0] gin;
    logic [15:0] gout;
    logic [4:0]  op;
    logic [15:0] cnt;
  } snap_t;

  localparam logic [15:0] PCOUT = 16'h8000, ZLOW = 16'h4000, ZHIGH = 16'h2000, MDROUT = 16'h1000;
  localparam logic [15:0] MARIN = 16'h0800, ZIN = 16'h0400, PCIN = 16'h0200, MDRIN = 16'h0100;
  localparam logic [15:0] IRIN = 16'h0080, YIN = 16'h0040, LOIN = 16'h0020, HIIN = 16'h0010;
  localparam logic [15:0] INCPC = 16'h0008, READ = 16'h0004, DONE = 16'h0002, ILL = 16'h0001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  control_sequencer_if #(.NREGS(16), .CNT_W(16)) d();
  control_sequencer_if #(.NREGS(16), .CNT_W(3))  w();

  control_sequencer #(.NREGS(16), .CNT_W(16)) dut (.Clock(clk), .Resetn(rst_n), .bus(d.master));
  control_sequencer #(.NREGS(16), .CNT_W(3))  u_wrap (.Clock(clk), .Resetn(rst_n), .bus(w.master));

  int    checks = 0;
  int    fails  = 0;
  snap_t q[$];

  function automatic snap_t snap();
    snap_t s;
    s.stb  = {d.PCout, d.Zlowout, d.Zhighout, d.MDRout, d.MARin, d.Zin, d.PCin, d.MDRin,
              d.IRin, d.Yin, d.LOin, d.HIin, d.IncPC, d.Read, d.Done, d.Illegal};
    s.gin  = d.GPRin;
    s.gout = d.GPRout;
    s.op   = d.ALU_op;
    s.cnt  = d.Instr_count;
    return s;
  endfunction

  function automatic snap_t ex(logic [15:0] stb, logic [15:0] gin, logic [15:0] gout,
                               logic [4:0] op, logic [15:0] cnt);
    snap_t s;
    s.stb = stb; s.gin = gin; s.gout = gout; s.op = op; s.cnt = cnt;
    return s;
  endfunction

  task automatic push_fetch(input logic [15:0] c);
    q.push_back(ex(PCOUT | MARIN | INCPC | ZIN, 16'h0, 16'h0, 5'd0, c));
    q.push_back(ex(ZLOW | PCIN | READ | MDRIN, 16'h0, 16'h0, 5'd0, c));
    q.push_back(ex(MDROUT | IRIN, 16'h0, 16'h0, 5'd0, c));
  endtask

  task automatic test_reset();
    snap_t o;
    d.Run = 1'b1; d.IR = 32'h0; w.Run = 1'b0; w.IR = 32'h0;
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      o = snap();
      checks++;
      if (o !== '0) begin fails++; $display("FAIL reset_outputs got=%h exp=0", o); end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_and();
    snap_t o, e; int k = 0;
    push_fetch(16'd0);
    q.push_back(ex(YIN, 16'h0, 16'h0004, 5'd9, 16'd0));
    q.push_back(ex(ZIN, 16'h0, 16'h0010, 5'd9, 16'd0));
    q.push_back(ex(ZLOW | DONE, 16'h0020, 16'h0, 5'd9, 16'd0));
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front(); o = snap(); checks++;
      if (o !== e) begin fails++; $display("FAIL and_cyc%0d got=%h exp=%h", k, o, e); end
      if (k == 1) d.IR = 32'h4A920000;
      k++;
    end
  endtask

  task automatic test_mul();
    snap_t o, e; int k = 0;
    push_fetch(16'd1);
    q.push_back(ex(YIN, 16'h0, 16'h0004, 5'd14, 16'd1));
    q.push_back(ex(ZIN, 16'h0, 16'h0010, 5'd14, 16'd1));
    q.push_back(ex(ZLOW | LOIN, 16'h0, 16'h0, 5'd14, 16'd1));
    q.push_back(ex(ZHIGH | HIIN | DONE, 16'h0, 16'h0, 5'd14, 16'd1));
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front(); o = snap(); checks++;
      if (o !== e) begin fails++; $display("FAIL mul_cyc%0d got=%h exp=%h", k, o, e); end
      if (k == 1) d.IR = 32'h72920000;
      k++;
    end
  endtask

  task automatic test_not();
    snap_t o, e; int k = 0;
    push_fetch(16'd2);
    q.push_back(ex(ZIN, 16'h0, 16'h0004, 5'd17, 16'd2));
    q.push_back(ex(ZLOW | DONE, 16'h0020, 16'h0, 5'd17, 16'd2));
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front(); o = snap(); checks++;
      if (o !== e) begin fails++; $display("FAIL not_cyc%0d got=%h exp=%h", k, o, e); end
      if (k == 1) d.IR = 32'h8A920000;
      k++;
    end
  endtask

  task automatic test_illegal();
    snap_t o, e; int k = 0;
    push_fetch(16'd3);
    q.push_back(ex(ILL, 16'h0, 16'h0, 5'd31, 16'd3));
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front(); o = snap(); checks++;
      if (o !== e) begin fails++; $display("FAIL illegal_cyc%0d got=%h exp=%h", k, o, e); end
      if (k == 1) d.IR = 32'hF8000000;
      k++;
    end
  endtask

  task automatic test_run_drop();
    snap_t o, e; int k = 0;
    push_fetch(16'd3);
    q.push_back(ex(YIN, 16'h0, 16'h0004, 5'd9, 16'd3));
    q.push_back(ex(ZIN, 16'h0, 16'h0010, 5'd9, 16'd3));
    q.push_back(ex(ZLOW | DONE, 16'h0020, 16'h0, 5'd9, 16'd3));
    q.push_back(ex(16'h0, 16'h0, 16'h0, 5'd0, 16'd4));
    q.push_back(ex(16'h0, 16'h0, 16'h0, 5'd0, 16'd4));
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front(); o = snap(); checks++;
      if (o !== e) begin fails++; $display("FAIL run_drop_cyc%0d got=%h exp=%h", k, o, e); end
      if (k == 1) d.IR = 32'h4A920000;
      if (k == 4) d.Run = 1'b0;
      k++;
    end
  endtask

  task automatic test_reset_in_t1();
    snap_t o;
    d.Run = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if ({d.Read, d.MDRin} !== 2'b11) begin
      fails++; $display("FAIL t1_before_reset got=%b exp=11", {d.Read, d.MDRin});
    end
    rst_n = 1'b0;
    #1;
    o = snap();
    checks++;
    if (o !== '0) begin fails++; $display("FAIL t1_async_reset got=%h exp=0", o); end
    @(negedge clk);
    o = snap();
    checks++;
    if (o !== '0) begin fails++; $display("FAIL t1_held_reset got=%h exp=0", o); end
  endtask

  task automatic test_wrap();
    d.Run = 1'b0;
    w.IR = 32'h8A920000;
    w.Run = 1'b1;
    rst_n = 1'b1;
    repeat (36) @(negedge clk);
    checks++;
    if (w.Instr_count !== 3'd7) begin
      fails++; $display("FAIL wrap_full got=%0d exp=7", w.Instr_count);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (w.Instr_count !== 3'd0) begin
      fails++; $display("FAIL wrap_zero got=%0d exp=0", w.Instr_count);
    end
    checks++;
    if (snap() !== '0) begin fails++; $display("FAIL wrap_main_idle got=%h exp=0", snap()); end
  endtask

  initial begin
    test_reset();
    test_and();
    test_mul();
    test_not();
    test_illegal();
    test_run_drop();
    test_reset_in_t1();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
